// File: rtl/mc_issue_ctrl.sv
// ============================================================================
// mc_issue_ctrl
// ----------------------------------------------------------------------------
// Issue/sequencing controller for the multi-cycle execution resources of the
// RV32IM core: the M-extension mul/div unit and the custom-0 encryption
// accelerator. When a multi-cycle instruction sits in decode it freezes
// fetch/decode, launches the matching unit with a one-cycle start pulse,
// waits for that unit's done handshake (bounded by a timeout), and then owns
// a single writeback cycle towards the GPR file. Single-cycle instructions
// pass through without touching any output.
//
// Parameters
//   TIMEOUT    maximum number of WAIT cycles before the sequence is aborted
//
// Ports
//   clk        in   core clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   id_valid   in   decoder presents a valid instruction
//   op         in   [6:0] decoder opcode
//   funct3     in   [2:0] decoder funct3
//   funct7     in   [6:0] decoder funct7
//   write_sel  in   [4:0] decoder destination register
//   flush      in   branch/JALR redirect, squashes the current decode slot
//   stall      out  freeze fetch and decode (combinational)
//   md_start   out  one-cycle launch pulse to the mul/div unit
//   md_op      out  [2:0] funct3 captured at acceptance
//   md_done    in   mul/div result valid
//   enc_start  out  one-cycle launch pulse to the encryption accelerator
//   enc_done   in   accelerator result valid
//   wb_en      out  GPR write strobe for the multi-cycle result
//   wb_sel     out  [1:0] result mux: 01 mul/div, 10 enc, 00 otherwise
//   wb_rd      out  [4:0] destination register of the multi-cycle write
//   err        out  sticky timeout flag
// ============================================================================
module mc_issue_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [4:0] write_sel,
    input  logic       flush,
    output logic       stall,
    output logic       md_start,
    output logic [2:0] md_op,
    input  logic       md_done,
    output logic       enc_start,
    input  logic       enc_done,
    output logic       wb_en,
    output logic [1:0] wb_sel,
    output logic [4:0] wb_rd,
    output logic       err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_CUST0  = 7'b0001011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Unit select values double as the writeback mux encoding.
    localparam logic [1:0] UNIT_NONE = 2'b00;
    localparam logic [1:0] UNIT_MD   = 2'b01;
    localparam logic [1:0] UNIT_ENC  = 2'b10;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MD_WAIT  = 2'd1,
        ST_ENC_WAIT = 2'd2,
        ST_WB       = 2'd3
    } state_t;

    state_t          state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [4:0]      rd_q,        rd_d;
    logic [1:0]      unit_q,      unit_d;
    logic [2:0]      md_op_q,     md_op_d;
    logic            md_start_q,  md_start_d;
    logic            enc_start_q, enc_start_d;
    logic            wb_en_q,     wb_en_d;
    logic [1:0]      wb_sel_q,    wb_sel_d;
    logic [4:0]      wb_rd_q,     wb_rd_d;
    logic            err_q,       err_d;

    logic            is_md_s;
    logic            is_enc_s;
    logic            is_multi_s;
    logic            accept_s;
    logic            waiting_s;
    logic            unit_done_s;
    logic            done_hit_s;
    logic            timeout_s;

    // ------------------------------------------------------------------
    // Decode classification and sequencing conditions
    // ------------------------------------------------------------------
    assign is_md_s    = (op == OP_REG) && (funct7 == F7_MULDIV);
    assign is_enc_s   = (op == OP_CUST0);
    assign is_multi_s = is_md_s | is_enc_s;

    assign accept_s   = (state_q == ST_IDLE) && id_valid && is_multi_s && !flush;
    assign waiting_s  = (state_q == ST_MD_WAIT) || (state_q == ST_ENC_WAIT);

    // Only the launched unit's done counts; the other unit's done is noise.
    assign unit_done_s = (state_q == ST_MD_WAIT) ? md_done : enc_done;

    // The start pulse is still on the wire in the first WAIT cycle, so a done
    // seen then belongs to an earlier operation and is not sampled.
    assign done_hit_s = waiting_s && !(md_start_q | enc_start_q) && unit_done_s;

    // A done arriving in the same cycle as the limit takes priority.
    assign timeout_s  = waiting_s && !done_hit_s && (cnt_q == CNT_MAX);

    assign stall      = accept_s | waiting_s;

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_q        <= 5'd0;
            unit_q      <= UNIT_NONE;
            md_op_q     <= 3'd0;
            md_start_q  <= 1'b0;
            enc_start_q <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_sel_q    <= UNIT_NONE;
            wb_rd_q     <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            unit_q      <= unit_d;
            md_op_q     <= md_op_d;
            md_start_q  <= md_start_d;
            enc_start_q <= enc_start_d;
            wb_en_q     <= wb_en_d;
            wb_sel_q    <= wb_sel_d;
            wb_rd_q     <= wb_rd_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic of the issue FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_md_s) begin
                        state_d = ST_MD_WAIT;
                    end else begin
                        state_d = ST_ENC_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MD_WAIT, ST_ENC_WAIT: begin
                if (done_hit_s) begin
                    state_d = ST_WB;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the counter, captured operands and registered outputs
    always_comb begin
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        unit_d      = unit_q;
        md_op_d     = md_op_q;
        md_start_d  = 1'b0;
        enc_start_d = 1'b0;
        wb_en_d     = 1'b0;
        wb_sel_d    = UNIT_NONE;
        wb_rd_d     = 5'd0;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    // Counter restarts for this operation; it already reads 1
                    // in the start-pulse cycle so it equals the WAIT cycle
                    // number and reaching TIMEOUT means the budget is spent.
                    cnt_d       = CNT_ONE;
                    rd_d        = write_sel;
                    md_op_d     = funct3;
                    unit_d      = is_md_s ? UNIT_MD : UNIT_ENC;
                    md_start_d  = is_md_s;
                    enc_start_d = is_enc_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_MD_WAIT, ST_ENC_WAIT: begin
                if (done_hit_s) begin
                    // Launch the writeback cycle; x0 completes silently.
                    wb_en_d  = (rd_q != 5'd0);
                    wb_sel_d = unit_q;
                    wb_rd_d  = rd_q;
                end else if (timeout_s) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WB: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign md_start  = md_start_q;
    assign enc_start = enc_start_q;
    assign md_op     = md_op_q;
    assign wb_en     = wb_en_q;
    assign wb_sel    = wb_sel_q;
    assign wb_rd     = wb_rd_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mc_issue_ctrl.sv
// ============================================================================
// tb_mc_issue_ctrl
// Directed bench for mc_issue_ctrl. A cycle-indexed reference model tracks
// the instruction in flight (accept cycle, unit, rd, writeback cycle) and a
// single compare process checks every DUT output against it on each falling
// edge. The stimulus also pins a few hand-computed literal values.
// ============================================================================
module tb_mc_issue_ctrl;

    localparam int TIMEOUT = 64;

    localparam logic [31:0] I_MUL_X5 = 32'h022082B3;
    localparam logic [31:0] I_MUL_X0 = 32'h02208033;
    localparam logic [31:0] I_ENC_X4 = 32'h0041A20B;
    localparam logic [31:0] I_DIV_X6 = 32'h0220C333;
    localparam logic [31:0] I_ADDI   = 32'h00500113;
    localparam logic [31:0] I_ADD    = 32'h004282B3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic [4:0] write_sel = 5'd0;
    logic       flush = 1'b0;
    logic       md_done = 1'b0;
    logic       enc_done = 1'b0;
    logic       stall;
    logic       md_start;
    logic [2:0] md_op;
    logic       enc_start;
    logic       wb_en;
    logic [1:0] wb_sel;
    logic [4:0] wb_rd;
    logic       err;

    mc_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .write_sel (write_sel),
        .flush     (flush),
        .stall     (stall),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_done   (md_done),
        .enc_start (enc_start),
        .enc_done  (enc_done),
        .wb_en     (wb_en),
        .wb_sel    (wb_sel),
        .wb_rd     (wb_rd),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int cur = 0;          // index of the current cycle
    bit m_busy = 1'b0;    // an accepted instruction has not finished yet
    int m_acc = 0;        // cycle it was accepted in
    int m_unit = 0;       // 1 mul/div, 2 enc
    int m_rd = 0;
    int m_md_op = 0;
    int m_wb_cyc = -1;    // cycle of its writeback, once known
    bit m_err = 1'b0;

    function automatic bit f_md();
        return (op == 7'h33) && (funct7 == 7'h01);
    endfunction

    function automatic bit f_multi();
        return f_md() || (op == 7'h0B);
    endfunction

    always @(posedge clk) begin
        int k;
        bit mine;
        if (rst) begin
            m_busy = 1'b0; m_err = 1'b0; m_md_op = 0; m_wb_cyc = -1;
        end else if (!m_busy) begin
            if (id_valid && f_multi() && !flush) begin
                m_busy = 1'b1; m_acc = cur; m_unit = f_md() ? 1 : 2;
                m_rd = int'(write_sel); m_md_op = int'(funct3); m_wb_cyc = -1;
            end
        end else if (m_wb_cyc == cur) begin
            m_busy = 1'b0;
        end else if (m_wb_cyc < 0) begin
            k = cur - m_acc;
            mine = (m_unit == 1) ? md_done : enc_done;
            if (k >= 2 && mine) m_wb_cyc = cur + 1;
            else if (k == TIMEOUT) begin m_busy = 1'b0; m_err = 1'b1; end
        end
        cur++;
    end

    // Compare every DUT output with the model in the middle of each cycle
    always @(negedge clk) begin
        bit in_wb;
        bit acc_now;
        if (chk_en) begin
            in_wb   = m_busy && (cur == m_wb_cyc);
            acc_now = !m_busy && id_valid && f_multi() && !flush;
            chk("stall",     32'(stall),     32'(acc_now || (m_busy && !in_wb)));
            chk("md_start",  32'(md_start),  32'(m_busy && m_unit == 1 && cur == m_acc + 1));
            chk("enc_start", 32'(enc_start), 32'(m_busy && m_unit == 2 && cur == m_acc + 1));
            chk("md_op",     32'(md_op),     32'(m_md_op));
            chk("wb_en",     32'(wb_en),     32'(in_wb && m_rd != 0));
            chk("wb_sel",    32'(wb_sel),    in_wb ? 32'(m_unit) : 32'd0);
            chk("wb_rd",     32'(wb_rd),     in_wb ? 32'(m_rd) : 32'd0);
            chk("err",       32'(err),       32'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic fl);
        id_valid  = 1'b1;
        op        = ins[6:0];
        write_sel = ins[11:7];
        funct3    = ins[14:12];
        funct7    = ins[31:25];
        flush     = fl;
    endtask

    task automatic idle_dec();
        id_valid = 1'b0;
        flush    = 1'b0;
    endtask

    int  n_stall;
    bit  seen_wb;

    initial begin
        // Reset
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_md_op", 32'(md_op), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // mul x5,x1,x2 with done at T+4
        present(I_MUL_X5, 1'b0);
        @(negedge clk); chk("mul_stall_T", 32'(stall), 32'd1);
        tick(); idle_dec();
        @(negedge clk); chk("mul_start_T1", 32'(md_start), 32'd1);
        tick();
        @(negedge clk); chk("mul_nostart_T2", 32'(md_start), 32'd0);
        tick();
        tick(); md_done = 1'b1;
        @(negedge clk); chk("mul_stall_T4", 32'(stall), 32'd1);
        tick(); md_done = 1'b0;
        @(negedge clk);
        chk("mul_wb_en", 32'(wb_en),  32'd1);
        chk("mul_wb_sel", 32'(wb_sel), 32'd1);
        chk("mul_wb_rd", 32'(wb_rd),  32'd5);
        chk("mul_md_op", 32'(md_op),  32'd0);
        chk("mul_stall_wb", 32'(stall), 32'd0);
        tick();

        // enc x4 with done at T+2
        present(I_ENC_X4, 1'b0);
        tick(); idle_dec();
        @(negedge clk); chk("enc_start_T1", 32'(enc_start), 32'd1);
        tick(); enc_done = 1'b1;
        tick(); enc_done = 1'b0;
        @(negedge clk);
        chk("enc_wb_sel", 32'(wb_sel), 32'd2);
        chk("enc_wb_rd",  32'(wb_rd),  32'd4);
        chk("enc_stall",  32'(stall),  32'd0);
        tick();

        // Plain instructions with stray done pulses
        present(I_ADDI, 1'b0); md_done = 1'b1;
        tick();
        present(I_ADD, 1'b0); md_done = 1'b0; enc_done = 1'b1;
        @(negedge clk); chk("add_stall", 32'(stall), 32'd0);
        tick(); idle_dec(); enc_done = 1'b0;
        tick();

        // mul presented with flush: not accepted
        present(I_MUL_X5, 1'b1);
        @(negedge clk); chk("flush_stall", 32'(stall), 32'd0);
        tick(); idle_dec();
        @(negedge clk); chk("flush_nostart", 32'(md_start), 32'd0);
        tick();

        // mul to x0, done at T+3: sequence runs, write suppressed
        present(I_MUL_X0, 1'b0);
        tick(); idle_dec();
        tick();
        tick(); md_done = 1'b1;
        tick(); md_done = 1'b0;
        @(negedge clk);
        chk("x0_wb_en",  32'(wb_en),  32'd0);
        chk("x0_wb_sel", 32'(wb_sel), 32'd1);
        tick();

        // enc with dones in the start cycle and a wrong-unit done: all ignored
        present(I_ENC_X4, 1'b0);
        tick(); idle_dec(); md_done = 1'b1; enc_done = 1'b1;
        tick(); enc_done = 1'b0;
        tick(); md_done = 1'b0;
        @(negedge clk); chk("wrong_done_stall", 32'(stall), 32'd1);
        tick();
        tick(); enc_done = 1'b1;
        tick(); enc_done = 1'b0;
        @(negedge clk); chk("late_enc_wb_rd", 32'(wb_rd), 32'd4);
        tick();

        // Timeout: enc never completes
        present(I_ENC_X4, 1'b0);
        n_stall = 0;
        seen_wb = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            n_stall++;
            if (wb_en) seen_wb = 1'b1;
            tick(); idle_dec();
        end
        chk("to_stall_cycles", 32'(n_stall), 32'd65);
        chk("to_no_wb", 32'(seen_wb), 32'd0);
        chk("to_err", 32'(err), 32'd1);
        tick();

        // div x6 after the timeout is still accepted; err stays set
        present(I_DIV_X6, 1'b0);
        tick(); idle_dec();
        tick(); md_done = 1'b1;
        tick(); md_done = 1'b0;
        @(negedge clk);
        chk("div_wb_rd", 32'(wb_rd), 32'd6);
        chk("div_md_op", 32'(md_op), 32'd4);
        chk("div_err",   32'(err),   32'd1);
        tick();

        // rst in MD_WAIT: everything clears next cycle
        present(I_MUL_X5, 1'b0);
        tick(); idle_dec();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_err",   32'(err),   32'd0);
        chk("rst_mid_start", 32'(md_start), 32'd0);
        tick(); md_done = 1'b1;
        tick(); md_done = 1'b0;
        @(negedge clk); chk("rst_mid_no_wb", 32'(wb_en), 32'd0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
